// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - bit-serial MSB-first magnitude comparator with start/busy/done handshake
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing bit instead of scanning all WIDTH bits.
module serial_comparator_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             decided_q, decided_d;
   logic             res_gt_q, res_gt_d;
   logic             res_lt_q, res_lt_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;

   logic bit_gt, bit_lt;
   logic fin_gt, fin_lt;
   logic exit_now;

   // One-bit compare cell on the current MSBs of the shifters
   assign bit_gt = a_sh_q[WIDTH-1] & ~b_sh_q[WIDTH-1];
   assign bit_lt = ~a_sh_q[WIDTH-1] & b_sh_q[WIDTH-1];

   // A recorded decision always wins over lower-order bits
   assign fin_gt   = decided_q ? res_gt_q : bit_gt;
   assign fin_lt   = decided_q ? res_lt_q : bit_lt;
   assign exit_now = (cnt_q == LAST_IDX) || (EARLY_EXIT && (bit_gt || bit_lt));

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      res_gt_d  = res_gt_q;
      res_lt_d  = res_lt_q;
      gt_d      = gt_q;
      lt_d      = lt_q;
      eq_d      = eq_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_COMPARE;
               a_sh_d    = a_in;
               b_sh_d    = b_in;
               cnt_d     = '0;
               decided_d = 1'b0;
               res_gt_d  = 1'b0;
               res_lt_d  = 1'b0;
               gt_d      = 1'b0;
               lt_d      = 1'b0;
               eq_d      = 1'b0;
            end
         end
         S_COMPARE: begin
            res_gt_d  = fin_gt;
            res_lt_d  = fin_lt;
            decided_d = decided_q | bit_gt | bit_lt;
            a_sh_d    = {a_sh_q[WIDTH-2:0], 1'b0};
            b_sh_d    = {b_sh_q[WIDTH-2:0], 1'b0};
            if (exit_now) begin
               state_d = S_DONE;
               gt_d    = fin_gt;
               lt_d    = fin_lt;
               eq_d    = ~(fin_gt | fin_lt);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         res_gt_q  <= 1'b0;
         res_lt_q  <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         eq_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         res_gt_q  <= res_gt_d;
         res_lt_q  <= res_lt_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
         eq_q      <= eq_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign gt   = gt_q;
   assign lt   = lt_q;
   assign eq   = eq_q;

endmodule

// File: doc/serial_comparator_ctrl.md
Name: serial_comparator_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands one bit per clock, MSB first, using a 1-bit compare cell (greater/less/equal per bit pair).
- Operands are latched on a start request and shifted through the cell. A first-difference decision register forms the final result.
- Provides a start/busy/done handshake so it can sit behind a bus or control FSM as a low-area magnitude comparator.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin a comparison; sampled only in IDLE
- a_in  input  WIDTH  operand A; latched on an accepted start
- b_in  input  WIDTH  operand B; latched on an accepted start
- busy  output  1  high while in COMPARE or DONE
- done  output  1  one-cycle pulse when the result is valid
- gt  output  1  A > B; held until the next accepted start
- lt  output  1  A < B; held until the next accepted start
- eq  output  1  A == B; held until the next accepted start

Behaviour:
- Reset: state=IDLE; busy, done, gt, lt, eq all 0. Shift registers, bit counter and decided flag are cleared. Reset has priority over all other inputs.
- States and transitions:
  - IDLE to COMPARE on start=1. The same edge latches a_in/b_in into a_sh/b_sh, clears counter and decided flag, and clears gt/lt/eq to 0.
  - COMPARE, each edge: the cell evaluates a_sh[WIDTH-1] vs b_sh[WIDTH-1]. If decided=0 and the bits differ, record g/l into internal res_gt/res_lt and set decided=1. Then shift a_sh/b_sh left by 1 and increment the counter.
  - COMPARE to DONE on the edge where counter==WIDTH-1 (last bit), or on an early-exit condition (see Optional Feature). On that edge, gt/lt are loaded from the final decision and eq = ~(gt|lt).
  - DONE to IDLE unconditionally on the next edge. done=1 only while state==DONE.
- Latency, measured from the start-accept edge to done high:
  - Full scan: WIDTH edges. done is high in the cycle after edge WIDTH.
  - Minimum period between accepted starts: WIDTH+2 edges.
- Result precedence: the MSB-most differing bit decides. Lower bits never override a decision once decided=1.
- Exactly one of gt/lt/eq is 1 after a completed comparison. All three are 0 from start-accept until completion.
- start while busy (COMPARE or DONE): ignored. Latched operands do not change.
- a_in/b_in changing after acceptance: no effect.
- rst mid-operation: aborts immediately to IDLE with all outputs 0. No done pulse. The next start is accepted normally.
- Counter width: $clog2(WIDTH); it never wraps within one operation.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN
- Defined: COMPARE goes to DONE on the first edge where the compared bits differ. Latency = WIDTH - i edges, where i is the index of the MSB-most differing bit. Equal operands still take WIDTH edges.
- Undefined: always WIDTH compare edges (fixed latency). The decided flag preserves the first difference.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, start one cycle -> busy high; done pulses 8 edges after accept; eq=1, gt=0, lt=0; busy low 1 cycle after done.
- a=0x80, b=0x7F -> gt=1. With SERIAL_CMP_EARLY_EXIT_EN, done pulses 1 edge after accept; without it, 8 edges.
- a=0x12, b=0x13 -> lt=1; done 8 edges after accept in both builds, since the differing bit is index 0.
- Accept a=0x40, b=0x20; 2 cycles later pulse start with a=0x00, b=0xFF -> second start ignored; result gt=1; exactly one done pulse.
- Accept a=0x01, b=0x02; assert rst for 1 cycle at the 3rd compare edge -> next cycle busy=done=gt=lt=eq=0, no done pulse. Then start a=0x03, b=0x03 -> eq=1 after 8 edges.
- start held high continuously, operands fixed a=0xF0, b=0x0F -> done pulses every WIDTH+2=10 edges (no early exit); gt=1 each time; gt drops to 0 on each re-accept edge.
